// File: rtl/jk_ff_exerciser_pkg.sv
// Shared types and the fixed vector table for the JK flip-flop exerciser.
package jk_ff_exerciser_pkg;

  localparam int unsigned NUM_STEPS = 8;
  localparam int unsigned STEP_W    = 3;

  typedef enum logic [2:0] {
    StIdle,
    StDrive,
    StHigh,
    StLow,
    StSample,
    StDone
  } state_e;

  // CLR/PRE steps exercise the async lines; SYNC steps pulse the DUT clock.
  typedef enum logic [1:0] {
    KindClr,
    KindPre,
    KindSync
  } step_kind_e;

  typedef struct packed {
    step_kind_e kind;
    logic       j;
    logic       k;
    logic       exp_q;
  } vector_t;

  // Step 7 drives K = ~J, i.e. the flop used as a D flop with D = 0.
  localparam vector_t VEC_ROM [NUM_STEPS] = '{
    '{kind: KindClr,  j: 1'b0, k: 1'b0, exp_q: 1'b0},
    '{kind: KindPre,  j: 1'b0, k: 1'b0, exp_q: 1'b1},
    '{kind: KindSync, j: 1'b0, k: 1'b0, exp_q: 1'b1},
    '{kind: KindSync, j: 1'b0, k: 1'b1, exp_q: 1'b0},
    '{kind: KindSync, j: 1'b1, k: 1'b0, exp_q: 1'b1},
    '{kind: KindSync, j: 1'b1, k: 1'b1, exp_q: 1'b0},
    '{kind: KindSync, j: 1'b1, k: 1'b1, exp_q: 1'b1},
    '{kind: KindSync, j: 1'b0, k: 1'b1, exp_q: 1'b0}
  };

  // Width of the phase timer; never narrower than one bit.
  function automatic int unsigned timer_width(input int unsigned hi, input int unsigned lo);
    int unsigned m;
    int unsigned w;
    m = (hi > lo) ? hi : lo;
    w = $clog2(m);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/ff_vector_rom.sv
// Combinational step-index to test-vector lookup.
module ff_vector_rom
  import jk_ff_exerciser_pkg::*;
(
  input  logic [STEP_W-1:0] step,
  output vector_t           vec
);

  assign vec = VEC_ROM[step];

endmodule

// File: rtl/jk_ff_exerciser.sv
// Sequencer that walks a JK master-slave flop through eight vectors and checks Q/Qbar.
module jk_ff_exerciser
  import jk_ff_exerciser_pkg::*;
#(
  parameter int unsigned HI_CYCLES    = 2,
  parameter int unsigned LO_CYCLES    = 2,
  parameter bit          STOP_ON_FAIL = 1'b1
) (
  input  logic              clk,
  input  logic              clr_bar,
  input  logic              start,
  input  logic              abort,
  input  logic              dut_q,
  input  logic              dut_qbar,
  output logic              dut_j,
  output logic              dut_k,
  output logic              dut_clk,
  output logic              dut_pre_bar,
  output logic              dut_clr_bar,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [STEP_W-1:0] fail_step,
  output logic [STEP_W-1:0] step
);

  localparam int unsigned        TimerW   = timer_width(HI_CYCLES, LO_CYCLES);
  localparam logic [TimerW-1:0]  HiLoad   = TimerW'(HI_CYCLES - 1);
  localparam logic [TimerW-1:0]  LoLoad   = TimerW'(LO_CYCLES - 1);
  localparam logic [STEP_W-1:0]  LastStep = STEP_W'(NUM_STEPS - 1);

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic                err_q, err_d;
  logic                pass_q, pass_d;
  logic [STEP_W-1:0]   fail_q, fail_d;
  step_kind_e          kind_q, kind_d;
  logic                want_q, want_d;
  logic                j_q, j_d;
  logic                k_q, k_d;
  logic                dclk_q, dclk_d;
  logic                pre_bar_q, pre_bar_d;
  logic                clr_bar_q, clr_bar_d;

  logic [STEP_W-1:0]   rom_idx;
  vector_t             vec;
  logic                mismatch;
  logic                load_vec;
  logic                go_idle;

  // The ROM is addressed with the step about to enter DRIVE, so J/K and the
  // async line are already registered on the edge that enters DRIVE.
  assign rom_idx = (state_q == StSample) ? step_q + 3'd1 : '0;

  ff_vector_rom u_rom (
    .step (rom_idx),
    .vec  (vec)
  );

  // Qbar must always be the complement of Q, independent of the expected value.
  assign mismatch = (dut_q != want_q) | (dut_qbar == dut_q);

  // Next-state, checker and registered DUT-line decisions.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    timer_d   = timer_q;
    err_d     = err_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    kind_d    = kind_q;
    want_d    = want_q;
    j_d       = j_q;
    k_d       = k_q;
    dclk_d    = dclk_q;
    pre_bar_d = pre_bar_q;
    clr_bar_d = clr_bar_q;
    load_vec  = 1'b0;
    go_idle   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StDrive;
          step_d   = '0;
          err_d    = 1'b0;
          fail_d   = '0;
          pass_d   = 1'b0;
          load_vec = 1'b1;
        end
      end
      StDrive: begin
        timer_d = HiLoad;
        state_d = StHigh;
        dclk_d  = (kind_q == KindSync);
      end
      StHigh: begin
        if (timer_q == '0) begin
          state_d   = StLow;
          timer_d   = LoLoad;
          dclk_d    = 1'b0;
          pre_bar_d = 1'b1;
          clr_bar_d = 1'b1;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      StLow: begin
        if (timer_q == '0) begin
          state_d = StSample;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      StSample: begin
        if (mismatch && !err_q) begin
          fail_d = step_q;
          err_d  = 1'b1;
        end
        if (mismatch && STOP_ON_FAIL) begin
          state_d = StDone;
          pass_d  = 1'b0;
          go_idle = 1'b1;
        end else if (step_q == LastStep) begin
          state_d = StDone;
          pass_d  = ~(err_q | mismatch);
          go_idle = 1'b1;
        end else begin
          step_d   = step_q + 1'b1;
          state_d  = StDrive;
          load_vec = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        go_idle = 1'b1;
      end
    endcase

    // Abort wins over any decision above, including the SAMPLE outcome.
    if (abort && (state_q inside {StDrive, StHigh, StLow, StSample})) begin
      state_d  = StIdle;
      step_d   = step_q;
      err_d    = 1'b0;
      pass_d   = 1'b0;
      fail_d   = '0;
      load_vec = 1'b0;
      go_idle  = 1'b1;
    end

    if (load_vec) begin
      kind_d    = vec.kind;
      want_d    = vec.exp_q;
      j_d       = vec.j;
      k_d       = vec.k;
      dclk_d    = 1'b0;
      clr_bar_d = (vec.kind != KindClr);
      pre_bar_d = (vec.kind != KindPre);
    end

    if (go_idle) begin
      j_d       = 1'b0;
      k_d       = 1'b0;
      dclk_d    = 1'b0;
      pre_bar_d = 1'b1;
      clr_bar_d = 1'b1;
    end
  end

  // State, checker and DUT-line registers.
  always_ff @(posedge clk or negedge clr_bar) begin
    if (!clr_bar) begin
      state_q   <= StIdle;
      step_q    <= '0;
      timer_q   <= '0;
      err_q     <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= '0;
      kind_q    <= KindClr;
      want_q    <= 1'b0;
      j_q       <= 1'b0;
      k_q       <= 1'b0;
      dclk_q    <= 1'b0;
      pre_bar_q <= 1'b1;
      clr_bar_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      timer_q   <= timer_d;
      err_q     <= err_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      kind_q    <= kind_d;
      want_q    <= want_d;
      j_q       <= j_d;
      k_q       <= k_d;
      dclk_q    <= dclk_d;
      pre_bar_q <= pre_bar_d;
      clr_bar_q <= clr_bar_d;
    end
  end

  assign dut_j       = j_q;
  assign dut_k       = k_q;
  assign dut_clk     = dclk_q;
  assign dut_pre_bar = pre_bar_q;
  assign dut_clr_bar = clr_bar_q;
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign pass        = pass_q;
  assign fail_step   = fail_q;
  assign step        = step_q;

endmodule

// File: tb/tb_jk_ff_exerciser.sv
// Bench: two exercisers (stop-on-fail and run-all) each driving a behavioural JK flop
// with selectable faults; results compared to a step-level prediction.
module tb_jk_ff_exerciser;

  localparam int NSTEPS   = 8;
  localparam int STEP_CYC = 6;
  localparam int F_NONE   = 0;
  localparam int F_KSTUCK = 1;
  localparam int F_QBTIED = 2;
  localparam int F_JSTUCK = 3;
  localparam int F_SWAP   = 4;

  // Vector table as the lab sheet lists it: kind 0=CLR 1=PRE 2=SYNC.
  int rk[NSTEPS] = '{0, 1, 2, 2, 2, 2, 2, 2};
  int rj[NSTEPS] = '{0, 0, 0, 0, 1, 1, 1, 0};
  int rkk[NSTEPS] = '{0, 0, 0, 1, 0, 1, 1, 1};
  int rq[NSTEPS] = '{0, 1, 1, 0, 1, 0, 1, 0};

  logic clk = 1'b0;
  logic clr_bar, start, abort;
  int   fault;

  logic j0, k0, c0, p0, r0, q0, qb0, busy0, done0, pass0;
  logic j1, k1, c1, p1, r1, q1, qb1, busy1, done1, pass1;
  logic [2:0] fs0, st0, fs1, st1;
  logic m0, m1;

  int checks = 0;
  int failures = 0;

  // Per-run observations.
  int dc0, dc1, dn0, dn1, rf0, rf1, pulses, highs, clrlow, clrbad, prelow, prebad;
  logic rp0, rp1;

  always #5 clk = ~clk;

  jk_ff_exerciser #(.HI_CYCLES(2), .LO_CYCLES(2), .STOP_ON_FAIL(1'b1)) u_dut_stop (
    .clk(clk), .clr_bar(clr_bar), .start(start), .abort(abort),
    .dut_q(q0), .dut_qbar(qb0), .dut_j(j0), .dut_k(k0), .dut_clk(c0),
    .dut_pre_bar(p0), .dut_clr_bar(r0), .busy(busy0), .done(done0), .pass(pass0),
    .fail_step(fs0), .step(st0)
  );

  jk_ff_exerciser #(.HI_CYCLES(2), .LO_CYCLES(2), .STOP_ON_FAIL(1'b0)) u_dut_all (
    .clk(clk), .clr_bar(clr_bar), .start(start), .abort(abort),
    .dut_q(q1), .dut_qbar(qb1), .dut_j(j1), .dut_k(k1), .dut_clk(c1),
    .dut_pre_bar(p1), .dut_clr_bar(r1), .busy(busy1), .done(done1), .pass(pass1),
    .fail_step(fs1), .step(st1)
  );

  function automatic logic jk_next(input logic q, input logic j, input logic k);
    case ({j, k})
      2'b00:   return q;
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      default: return ~q;
    endcase
  endfunction

  // Behavioural master-slave JK flops: output changes on the clock falling edge.
  always @(negedge c0 or negedge p0 or negedge r0) begin
    if (r0 === 1'b0) m0 = 1'b0;
    else if (p0 === 1'b0) m0 = 1'b1;
    else m0 = jk_next(m0, (fault == F_JSTUCK) ? 1'b0 : j0, (fault == F_KSTUCK) ? 1'b0 : k0);
  end

  always @(negedge c1 or negedge p1 or negedge r1) begin
    if (r1 === 1'b0) m1 = 1'b0;
    else if (p1 === 1'b0) m1 = 1'b1;
    else m1 = jk_next(m1, (fault == F_JSTUCK) ? 1'b0 : j1, (fault == F_KSTUCK) ? 1'b0 : k1);
  end

  assign q0  = (fault == F_SWAP) ? ~m0 : m0;
  assign qb0 = (fault == F_QBTIED) ? q0 : ~q0;
  assign q1  = (fault == F_SWAP) ? ~m1 : m1;
  assign qb1 = (fault == F_QBTIED) ? q1 : ~q1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Step-level prediction of the run outcome for a given fault.
  function automatic void predict(input int flt, input bit stop, output bit p, output int fs,
                                  output int cyc);
    int q, jj, kk, qo, qbo;
    bit err, mis;
    q = 0;
    err = 1'b0;
    fs = 0;
    cyc = NSTEPS * STEP_CYC;
    for (int s = 0; s < NSTEPS; s++) begin
      if (rk[s] == 0) q = 0;
      else if (rk[s] == 1) q = 1;
      else begin
        jj = (flt == F_JSTUCK) ? 0 : rj[s];
        kk = (flt == F_KSTUCK) ? 0 : rkk[s];
        if (jj == 1 && kk == 1) q = 1 - q;
        else if (jj == 1) q = 1;
        else if (kk == 1) q = 0;
      end
      qo  = (flt == F_SWAP) ? 1 - q : q;
      qbo = (flt == F_QBTIED) ? qo : 1 - qo;
      mis = (qo != rq[s]) || (qbo == qo);
      if (mis && !err) begin
        err = 1'b1;
        fs = s;
        if (stop) begin
          cyc = (s + 1) * STEP_CYC;
          break;
        end
      end
    end
    p = !err;
  endfunction

  // One start pulse, then 61 sampled cycles; cycle 0 is the edge that samples start.
  task automatic run(input int flt, input int extra_start);
    logic prev_c;
    fault = flt;
    dc0 = -1; dc1 = -1; dn0 = 0; dn1 = 0; rf0 = 0; rf1 = 0; rp0 = 1'b0; rp1 = 1'b0;
    pulses = 0; highs = 0; clrlow = 0; clrbad = 0; prelow = 0; prebad = 0;
    prev_c = 1'b0;
    @(posedge clk);
    #1 start = 1'b1;
    for (int c = 0; c <= 60; c++) begin
      @(posedge clk);
      #1;
      start = (c == extra_start);
      if (done0) begin
        if (dc0 < 0) begin dc0 = c; rp0 = pass0; rf0 = int'(fs0); end
        dn0++;
      end
      if (done1) begin
        if (dc1 < 0) begin dc1 = c; rp1 = pass1; rf1 = int'(fs1); end
        dn1++;
      end
      if (c0 && !prev_c) pulses++;
      if (c0) highs++;
      prev_c = c0;
      if (!r0) begin clrlow++; if (st0 != 3'd0) clrbad++; end
      if (!p0) begin prelow++; if (st0 != 3'd1) prebad++; end
    end
    start = 1'b0;
  endtask

  typedef struct {
    int flt;
    int p0; int f0; int c0;
    int p1; int f1; int c1;
  } vec_t;

  vec_t tbl[5];

  initial begin
    bit   pp;
    int   pf, pc, flt, xs;

    tbl[0] = '{F_NONE,   1, 0, 48, 1, 0, 48};
    tbl[1] = '{F_KSTUCK, 0, 3, 24, 0, 3, 48};
    tbl[2] = '{F_QBTIED, 0, 0,  6, 0, 0, 48};
    tbl[3] = '{F_JSTUCK, 0, 4, 30, 0, 4, 48};
    tbl[4] = '{F_SWAP,   0, 0,  6, 0, 0, 48};

    fault = F_NONE; start = 1'b0; abort = 1'b0; clr_bar = 1'b0;
    #12;
    check("rst_busy", int'(busy0), 0);
    check("rst_done", int'(done0), 0);
    check("rst_pass", int'(pass0), 0);
    check("rst_fail_step", int'(fs0), 0);
    check("rst_step", int'(st0), 0);
    check("rst_lines", int'({j0, k0, c0, p0, r0}), 5'b00011);
    @(negedge clk);
    clr_bar = 1'b1;

    // Table-driven fault scenarios.
    for (int i = 0; i < 5; i++) begin
      run(tbl[i].flt, -1);
      check($sformatf("t%0d_stop_done_cyc", i), dc0, tbl[i].c0);
      check($sformatf("t%0d_stop_pass", i), int'(rp0), tbl[i].p0);
      check($sformatf("t%0d_stop_fail_step", i), rf0, tbl[i].f0);
      check($sformatf("t%0d_stop_done_width", i), dn0, 1);
      check($sformatf("t%0d_all_done_cyc", i), dc1, tbl[i].c1);
      check($sformatf("t%0d_all_pass", i), int'(rp1), tbl[i].p1);
      check($sformatf("t%0d_all_fail_step", i), rf1, tbl[i].f1);
      check($sformatf("t%0d_pass_held", i), int'(pass0), tbl[i].p0);
      if (i == 0) begin
        check("wave_clk_pulses", pulses, 6);
        check("wave_clk_high_cycles", highs, 12);
        check("wave_clr_low_cycles", clrlow, 3);
        check("wave_clr_outside_step0", clrbad, 0);
        check("wave_pre_low_cycles", prelow, 3);
        check("wave_pre_outside_step1", prebad, 0);
      end
    end

    // Abort during step 4 HIGH.
    fault = F_NONE;
    @(posedge clk);
    #1 start = 1'b1;
    for (int c = 0; c <= 25; c++) begin
      @(posedge clk);
      #1 start = 1'b0;
    end
    check("abort_pre_step", int'(st0), 4);
    check("abort_pre_clk_high", int'(c0), 1);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("abort_busy", int'(busy0), 0);
    check("abort_lines", int'({j0, k0, c0, p0, r0}), 5'b00011);
    check("abort_pass", int'(pass0), 0);
    check("abort_fail_step", int'(fs0), 0);
    dn0 = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1 if (done0) dn0++;
    end
    check("abort_no_done", dn0, 0);

    // Let a passing run leave pass=1, then reset in the middle of step 5.
    run(F_NONE, -1);
    check("prereset_pass", int'(pass0), 1);
    @(posedge clk);
    #1 start = 1'b1;
    for (int c = 0; c <= 32; c++) begin
      @(posedge clk);
      #1 start = 1'b0;
    end
    check("prereset_step", int'(st0), 5);
    clr_bar = 1'b0;
    #1;
    check("midrst_busy", int'(busy0), 0);
    check("midrst_step", int'(st0), 0);
    check("midrst_lines", int'({j0, k0, c0, p0, r0}), 5'b00011);
    check("midrst_pass", int'(pass0), 0);
    check("midrst_done", int'(done0), 0);
    #1 clr_bar = 1'b1;
    run(F_NONE, 10);
    check("postrst_done_cyc", dc0, 48);
    check("postrst_pass", int'(rp0), 1);
    check("postrst_done_width", dn0, 1);

    // Randomized faults with a stray start while busy, against the prediction.
    for (int n = 0; n < 12; n++) begin
      flt = int'($urandom_range(0, 4));
      predict(flt, 1'b1, pp, pf, pc);
      xs = int'($urandom_range(1, pc - 1));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      run(flt, xs);
      check($sformatf("r%0d_f%0d_stop_cyc", n, flt), dc0, pc);
      check($sformatf("r%0d_f%0d_stop_pass", n, flt), int'(rp0), int'(pp));
      check($sformatf("r%0d_f%0d_stop_fail_step", n, flt), rf0, pf);
      predict(flt, 1'b0, pp, pf, pc);
      check($sformatf("r%0d_f%0d_all_cyc", n, flt), dc1, pc);
      check($sformatf("r%0d_f%0d_all_pass", n, flt), int'(rp1), int'(pp));
      check($sformatf("r%0d_f%0d_all_fail_step", n, flt), rf1, pf);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jk_ff_exerciser.md
# jk_ff_exerciser

Self-checking stimulus controller for one gate-level JK master-slave flip-flop under test (DUT), including the JK-wired-as-D configuration. On `start` it steps through a fixed 8-step vector sequence. Each step drives J/K, the asynchronous preset/clear lines and a generated DUT clock, then samples Q/Qbar against a built-in expected value. It reports pass/fail and the first failing step, and is the lab-bench sequencer that sits between the board switches/LEDs and the flip-flop netlist.

## Interface
- `HI_CYCLES`, default 2: system cycles `dut_clk` is held high per step (≥1)
- `LO_CYCLES`, default 2: system cycles `dut_clk` is held low before sampling (≥1)
- `STOP_ON_FAIL`, default 1: 1 = end the run at the first mismatch; 0 = run all 8 steps
- `clk` input 1: system clock; all state changes on rising edge
- `clr_bar` input 1: asynchronous, active-low reset
- `start` input 1: begin a run; sampled only in IDLE
- `abort` input 1: synchronous cancel of a run in progress
- `dut_q`, `dut_qbar` input 1 each: DUT outputs
- `dut_j`, `dut_k` output 1 each: DUT data inputs
- `dut_clk` output 1: generated DUT clock
- `dut_pre_bar`, `dut_clr_bar` output 1 each: DUT async preset/clear, active-low
- `busy` output 1: run in progress
- `done` output 1: one-cycle pulse at run end
- `pass` output 1: result of the last completed run; held until the next `start`
- `fail_step` output 3: index of the first failing step; valid when `pass`=0 after `done`
- `step` output 3: current step index

## Operation
- Vector ROM (step: kind, J, K, expected Q):
  - 0: CLR, 0, 0, 0
  - 1: PRE, 0, 0, 1
  - 2: SYNC, 0, 0, 1 (hold)
  - 3: SYNC, 0, 1, 0 (reset)
  - 4: SYNC, 1, 0, 1 (set)
  - 5: SYNC, 1, 1, 0 (toggle)
  - 6: SYNC, 1, 1, 1 (toggle)
  - 7: SYNC, 0, 1, 0 (D-mode, D=0)
- States: IDLE, DRIVE, HIGH, LOW, SAMPLE, DONE.
- IDLE: `dut_j`=`dut_k`=`dut_clk`=0, `dut_pre_bar`=`dut_clr_bar`=1, `busy`=0.
  - `start`=1: go to DRIVE, set `step`=0, clear the error flag and `fail_step`, clear `pass`.
- DRIVE (1 cycle):
  - Register J/K from the ROM.
  - CLR step: `dut_clr_bar`=0. PRE step: `dut_pre_bar`=0.
  - Load timer with HI_CYCLES-1, then go to HIGH.
- HIGH:
  - SYNC step: `dut_clk`=1. Async step: `dut_clk` stays 0 and the async line stays asserted.
  - Timer at 0: go to LOW with timer loaded to LO_CYCLES-1.
- LOW: `dut_clk`=0, both async lines released to 1, J/K held. Timer at 0: go to SAMPLE.
- SAMPLE (1 cycle): mismatch if `dut_q`≠expected or `dut_qbar`≠~`dut_q`.
  - First mismatch: latch `fail_step`=`step` and set the error flag.
  - Mismatch and STOP_ON_FAIL=1: go to DONE.
  - Else if `step`=7: go to DONE.
  - Else: `step`+1, go to DRIVE.
- DONE (1 cycle): `done`=1, `pass`=~error, DUT lines at idle values, then go to IDLE.
- `busy`=1 in DRIVE, HIGH, LOW, SAMPLE and DONE.
- `start` while busy: ignored.
- `abort` (any busy state except DONE):
  - Next state IDLE, DUT lines at idle values.
  - No `done` pulse; `pass`=0, `fail_step`=0.
  - `abort` has priority over every SAMPLE decision.
- Reset (asynchronous, also mid-run):
  - State IDLE, `step`=0, error flag cleared.
  - All outputs at IDLE values; `done`=`pass`=`fail_step`=0.

## Timing
- Cycles per step: 2+HI_CYCLES+LO_CYCLES; defaults give 6.
- `done` pulses 8·(2+HI+LO) cycles after the edge that samples `start` (48 with defaults), or earlier on a stop-on-fail.
- DUT outputs are registered; they change on the edge entering DRIVE, HIGH or LOW.
- The DUT's master-slave output settles on the `dut_clk` falling edge, at least LO_CYCLES before the SAMPLE edge.
- J/K are stable for the whole step, including the falling edge of `dut_clk`.
- `dut_q`/`dut_qbar` are sampled only in SAMPLE; no input synchronizer (same clock domain).
- Timer width: $clog2(max(HI_CYCLES,LO_CYCLES)); minimum 1 bit.

## Structure
- Package `jk_ff_exerciser_pkg`:
  - state enum
  - step-kind enum (CLR, PRE, SYNC)
  - vector struct {kind, j, k, exp_q}
  - NUM_STEPS=8
  - ROM constant array
- One sub-module, `ff_vector_rom`: combinational step → vector lookup.
- FSM, timer and checker live in the top module.

## Test plan
- Correct JK model, default parameters, `start` pulse:
  - `done` asserts 48 cycles later with `pass`=1.
  - `dut_clk` shows 6 high pulses of 2 cycles each.
  - `dut_clr_bar` low during step 0 only; `dut_pre_bar` low during step 1 only.
- DUT with K stuck at 0, STOP_ON_FAIL=1: `done` asserts at the end of step 3 (24 cycles) with `pass`=0 and `fail_step`=3.
- Same faulty DUT, STOP_ON_FAIL=0: all 8 steps run, `done` at 48 cycles, `pass`=0, `fail_step`=3 (the first failure, not the last).
- DUT with Qbar tied to Q: fail at step 0, `fail_step`=0.
- `abort` in step 4 HIGH: next cycle `busy`=0, all DUT lines idle, no `done` pulse, `pass`=0.
- `clr_bar` pulsed low mid-step 5, then `start` reasserted while busy and after reset: the busy-state `start` is ignored; the post-reset run completes with `pass`=1.
